// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download controller: FSM states and the
// byte-address to ROM-region decode.
package rom_dl_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, TAIL} state_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [26:0] base;
  } region_t;

  // One-hot bank select plus the base to subtract; out-of-range gives we=0.
  function automatic region_t decode_region(input logic [26:0] a,
                                            input logic [26:0] b1,
                                            input logic [26:0] b2,
                                            input logic [26:0] b3,
                                            input logic [26:0] bend);
    region_t r;
    r.we   = 4'b0000;
    r.base = '0;
    if (a < b1) begin
      r.we = 4'b0001;
    end else if (a < b2) begin
      r.we   = 4'b0010;
      r.base = b1;
    end else if (a < b3) begin
      r.we   = 4'b0100;
      r.base = b2;
    end else if (a < bend) begin
      r.we   = 4'b1000;
      r.base = b3;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: splits ioctl words into byte writes, arbitrates
// the ROM banks between loader and CPU, and holds the CPUs in reset.
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter int          AW       = 16,
  parameter logic [26:0] B1       = 27'h04000,
  parameter logic [26:0] B2       = 27'h08000,
  parameter logic [26:0] B3       = 27'h0C000,
  parameter logic [26:0] BEND     = 27'h10000,
  parameter int          HOLD_CYC = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [26:0]   ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  input  logic          ioctl_wr,
  output logic          ioctl_wait,
  input  logic [AW-1:0] cpu_ab,
  output logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_din,
  output logic [3:0]    rom_we,
  output logic          cpu_hold,
  output logic          dl_done,
  output logic [15:0]   checksum,
  output logic          overrun
);

  state_t      state;
  logic        dl_prev;
  logic [25:0] word_addr;
  logic [7:0]  hi_data;
  logic [15:0] hold_cnt;

  logic        dl_rise;
  logic        dl_fall;
  logic [26:0] acc_byte;
  logic [26:0] hi_byte;
  region_t     acc_reg;
  region_t     hi_reg;
  logic        addr_lsb_unused;

  assign dl_rise         = ioctl_download & ~dl_prev;
  assign dl_fall         = ~ioctl_download & dl_prev;
  assign acc_byte        = {ioctl_addr[26:1], 1'b0};
  assign hi_byte         = {word_addr, 1'b1};
  assign acc_reg         = decode_region(acc_byte, B1, B2, B3, BEND);
  assign hi_reg          = decode_region(hi_byte, B1, B2, B3, BEND);
  assign addr_lsb_unused = ioctl_addr[0];

  // The even byte is issued on the accepting edge so LO already shows it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      dl_prev    <= 1'b0;
      word_addr  <= '0;
      hi_data    <= '0;
      hold_cnt   <= 16'(HOLD_CYC);
      ioctl_wait <= 1'b0;
      rom_addr   <= '0;
      rom_din    <= '0;
      rom_we     <= '0;
      cpu_hold   <= 1'b1;
      dl_done    <= 1'b0;
      checksum   <= '0;
      overrun    <= 1'b0;
    end else begin
      dl_prev  <= ioctl_download;
      dl_done  <= 1'b0;
      rom_we   <= '0;
      rom_addr <= cpu_ab;
      case (state)
        IDLE: begin
          hold_cnt <= 16'(HOLD_CYC);
          if (dl_rise) begin
            checksum <= '0;
            overrun  <= 1'b0;
            cpu_hold <= 1'b1;
          end
          if (ioctl_download && ioctl_wr) begin
            word_addr  <= ioctl_addr[26:1];
            hi_data    <= ioctl_dout[15:8];
            state      <= LO;
            ioctl_wait <= 1'b1;
            rom_addr   <= AW'(acc_byte - acc_reg.base);
            rom_din    <= ioctl_dout[7:0];
            rom_we     <= acc_reg.we;
            if (acc_reg.we != 4'b0000)
              checksum <= (dl_rise ? 16'h0000 : checksum) + {8'h00, ioctl_dout[7:0]};
          end else if (dl_fall) begin
            state <= TAIL;
          end
        end
        LO: begin
          if (ioctl_wr) overrun <= 1'b1;
          state    <= HI;
          rom_addr <= AW'(hi_byte - hi_reg.base);
          rom_din  <= hi_data;
          rom_we   <= hi_reg.we;
          if (hi_reg.we != 4'b0000)
            checksum <= checksum + {8'h00, hi_data};
        end
        HI: begin
          if (ioctl_wr) overrun <= 1'b1;
          ioctl_wait <= 1'b0;
          state      <= ioctl_download ? IDLE : TAIL;
        end
        TAIL: begin
          // A fresh download aborts the tail and keeps the CPUs held.
          if (dl_rise) begin
            state    <= IDLE;
            checksum <= '0;
            overrun  <= 1'b0;
            hold_cnt <= 16'(HOLD_CYC);
          end else if (hold_cnt == 16'd1) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
            dl_done  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Self-checking bench for rom_dl_ctrl: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_rom_dl_ctrl;

  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [15:0] cpu_ab;
  logic [15:0] rom_addr;
  logic [7:0]  rom_din;
  logic [3:0]  rom_we;
  logic        cpu_hold;
  logic        dl_done;
  logic [15:0] checksum;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  rom_dl_ctrl #(.AW(16), .HOLD_CYC(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .ioctl_wait(ioctl_wait), .cpu_ab(cpu_ab), .rom_addr(rom_addr),
    .rom_din(rom_din), .rom_we(rom_we), .cpu_hold(cpu_hold),
    .dl_done(dl_done), .checksum(checksum), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word is busy for two edges after acceptance,
  // regions are 16 KiB slices of the byte space, the tail counts cycles.
  bit          m_valid = 0;
  bit          m_prev;
  int          m_busy;
  int          m_tail;
  logic [26:0] m_hi_addr;
  logic [7:0]  m_hi_byte;
  logic        e_wait, e_hold, e_done, e_ov;
  logic [3:0]  e_we;
  logic [15:0] e_addr, e_cs;
  logic [7:0]  e_din;
  bit          e_addr_chk;

  task automatic modelWrite(input logic [26:0] a, input logic [7:0] b);
    int idx;
    idx = int'(a) / 16384;
    if (idx < 4) begin
      e_we   = 4'(1 << idx);
      e_addr = 16'(int'(a) % 16384);
      e_din  = b;
      e_cs   = e_cs + {8'h00, b};
    end else begin
      e_addr_chk = 0;
    end
  endtask

  always @(posedge clk_sys) begin
    bit rise, fall;
    rise = ioctl_download && !m_prev;
    fall = !ioctl_download && m_prev;
    e_done     = 1'b0;
    e_we       = 4'b0000;
    e_addr     = cpu_ab;
    e_addr_chk = 1;
    if (reset) begin
      m_valid = 1; m_prev = 0; m_busy = 0; m_tail = -1;
      e_wait = 0; e_hold = 1; e_ov = 0; e_cs = 16'h0; e_din = 8'h00; e_addr = 16'h0;
    end else begin
      m_prev = ioctl_download;
      if (m_busy > 0) begin
        if (ioctl_wr) e_ov = 1'b1;
        if (m_busy == 2) begin
          modelWrite(m_hi_addr, m_hi_byte);
          m_busy = 1;
        end else begin
          m_busy = 0;
          e_wait = 1'b0;
          if (!ioctl_download) m_tail = HOLD;
        end
      end else if (m_tail >= 0) begin
        if (rise) begin
          m_tail = -1; e_cs = 16'h0; e_ov = 1'b0;
        end else begin
          m_tail--;
          if (m_tail == 0) begin
            m_tail = -1; e_hold = 1'b0; e_done = 1'b1;
          end
        end
      end else begin
        if (rise) begin
          e_cs = 16'h0; e_ov = 1'b0; e_hold = 1'b1;
        end
        if (ioctl_download && ioctl_wr) begin
          m_hi_addr = {ioctl_addr[26:1], 1'b1};
          m_hi_byte = ioctl_dout[15:8];
          modelWrite({ioctl_addr[26:1], 1'b0}, ioctl_dout[7:0]);
          m_busy = 2;
          e_wait = 1'b1;
        end else if (fall) begin
          m_tail = HOLD;
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (m_valid) begin
      checkOutput("ioctl_wait", 32'(ioctl_wait), 32'(e_wait));
      checkOutput("rom_we", 32'(rom_we), 32'(e_we));
      checkOutput("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      checkOutput("dl_done", 32'(dl_done), 32'(e_done));
      checkOutput("checksum", 32'(checksum), 32'(e_cs));
      checkOutput("overrun", 32'(overrun), 32'(e_ov));
      if (e_addr_chk) checkOutput("rom_addr", 32'(rom_addr), 32'(e_addr));
      if (e_we != 4'b0000) checkOutput("rom_din", 32'(rom_din), 32'(e_din));
    end
  end

  // Drive one cycle of loader inputs, then return after the sampling edge.
  task automatic applyStimulus(input logic dl, input logic wr, input logic [26:0] a, input logic [15:0] d);
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    @(negedge clk_sys);
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_ab = 16'h1234;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_we", 32'(rom_we), 32'h0);
    checkOutput("rst_hold", 32'(cpu_hold), 32'h1);
    checkOutput("rst_din", 32'(rom_din), 32'h0);
    checkOutput("rst_cs", 32'(checksum), 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
    applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
    checkOutput("idle_addr", 32'(rom_addr), 32'h1234);
    checkOutput("idle_hold", 32'(cpu_hold), 32'h1);

    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    applyStimulus(1'b1, 1'b1, 27'h0, 16'hA55A);
    checkOutput("w0_lo_we", 32'(rom_we), 32'h1);
    checkOutput("w0_lo_din", 32'(rom_din), 32'h5A);
    checkOutput("w0_lo_wait", 32'(ioctl_wait), 32'h1);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("w0_hi_addr", 32'(rom_addr), 32'h1);
    checkOutput("w0_hi_din", 32'(rom_din), 32'hA5);
    checkOutput("w0_cs", 32'(checksum), 32'h00FF);
    checkOutput("w0_hi_wait", 32'(ioctl_wait), 32'h1);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("w0_wait_drop", 32'(ioctl_wait), 32'h0);

    applyStimulus(1'b1, 1'b1, 27'h04002, 16'h0102);
    checkOutput("r1_lo_we", 32'(rom_we), 32'h2);
    checkOutput("r1_lo_addr", 32'(rom_addr), 32'h2);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("r1_hi_addr", 32'(rom_addr), 32'h3);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    applyStimulus(1'b1, 1'b1, 27'h10000, 16'hFFFF);
    checkOutput("oor_lo_we", 32'(rom_we), 32'h0);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("oor_hi_we", 32'(rom_we), 32'h0);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("oor_cs", 32'(checksum), 32'h0102);

    applyStimulus(1'b1, 1'b1, 27'h08000, 16'h1111);
    applyStimulus(1'b1, 1'b1, 27'h0, 16'hEEEE);
    checkOutput("ovr_flag", 32'(overrun), 32'h1);
    checkOutput("ovr_hi_din", 32'(rom_din), 32'h11);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("ovr_no_third", 32'(rom_we), 32'h0);
    checkOutput("ovr_cs", 32'(checksum), 32'h0124);

    applyStimulus(1'b1, 1'b1, 27'h0C000, 16'h0304);
    checkOutput("tl_lo_we", 32'(rom_we), 32'h8);
    applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
    checkOutput("tl_hi_we", 32'(rom_we), 32'h8);
    checkOutput("tl_hi_din", 32'(rom_din), 32'h03);
    applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
    for (int k = 1; k < HOLD; k++) begin
      applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
      checkOutput("tl_hold", 32'(cpu_hold), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
    checkOutput("tl_release", 32'(cpu_hold), 32'h0);
    checkOutput("tl_done", 32'(dl_done), 32'h1);
    applyStimulus(1'b0, 1'b0, 27'h0, 16'h0);
    checkOutput("tl_done_pulse", 32'(dl_done), 32'h0);
    checkOutput("tl_cs", 32'(checksum), 32'h012B);

    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("rise_ovr_clr", 32'(overrun), 32'h0);
    checkOutput("rise_hold", 32'(cpu_hold), 32'h1);

    applyStimulus(1'b1, 1'b1, 27'h2, 16'h0505);
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 27'h0, 16'h0);
    checkOutput("mrst_we", 32'(rom_we), 32'h0);
    checkOutput("mrst_wait", 32'(ioctl_wait), 32'h0);
    checkOutput("mrst_cs", 32'(checksum), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      logic dl, wr;
      reset  = ($urandom_range(0, 599) == 0);
      cpu_ab = 16'($urandom);
      dl = ioctl_download;
      if (ioctl_download && $urandom_range(0, 29) == 0) dl = 1'b0;
      else if (!ioctl_download && m_busy == 0 && $urandom_range(0, 24) == 0) dl = 1'b1;
      wr = !(dl && !ioctl_download) && ($urandom_range(0, 2) == 0) &&
           (m_busy == 0 || $urandom_range(0, 9) == 0);
      applyStimulus(dl, wr, 27'($urandom_range(0, 27'h13FFF)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_dl_ctrl.md
Name: rom_dl_ctrl

Overview:
- Sequences ROM download into the per-CPU 8-bit ROM banks and arbitrates each bank between the loader and the CPU.
- Splits each 16-bit ioctl word into two byte writes on consecutive cycles, decodes the target region, and back-pressures the loader via ioctl_wait.
- Holds the CPUs in reset during download and for a programmable tail afterwards.
- Sits between the framework ioctl bus and the mcpu/scpu ROM RAM instances.

Parameters:
- AW, 16, byte address width driven to ROM banks.
- B1, 27'h04000, first byte address of region 1 (region 0 = [0,B1)).
- B2, 27'h08000, first byte address of region 2.
- B3, 27'h0C000, first byte address of region 3.
- BEND, 27'h10000, first byte address past region 3; writes at or above are dropped.
- HOLD_CYC, 16, cycles cpu_hold stays high after ioctl_download falls (minimum 1).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download in progress
- ioctl_addr  in  27  byte address of word; bit 0 ignored (word aligned)
- ioctl_dout  in  16  data word; [7:0] goes to even byte, [15:8] to odd byte
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_wait  out  1  loader must not strobe while high
- cpu_ab  in  AW  CPU address when not downloading
- rom_addr  out  AW  address to all ROM banks (region-relative when loading)
- rom_din  out  8  byte to ROM banks
- rom_we  out  4  one-hot write enable, bit n = region n
- cpu_hold  out  1  CPU reset/hold
- dl_done  out  1  one-cycle pulse when the hold releases
- checksum  out  16  mod-2^16 sum of all bytes written in the last download
- overrun  out  1  sticky: ioctl_wr seen while ioctl_wait high

Behaviour:
- Reset values: ioctl_wait=0, rom_we=0, rom_din=0, cpu_hold=1, dl_done=0, checksum=0, overrun=0, FSM=IDLE. The hold counter loads HOLD_CYC.
- FSM states: IDLE, LO, HI, TAIL.
- IDLE:
  - Rising edge of ioctl_download clears checksum and overrun and sets cpu_hold=1.
  - ioctl_wr with ioctl_download=1 latches addr[26:1] and dout, then goes to LO. ioctl_wait=1 from the next cycle.
- LO: drives rom_addr = latched byte addr (even) minus region base, rom_din = dout[7:0], rom_we = region one-hot. Goes to HI.
- HI: same with addr+1 and dout[15:8]. Returns to IDLE; ioctl_wait drops in that same transition. Throughput is one word per 3 cycles.
- Region decode uses the byte address in each state:
  - addr < B1 → bit0; < B2 → bit1; < B3 → bit2; < BEND → bit3.
  - Otherwise rom_we=0 and the checksum is not updated.
  - A word straddling a boundary (odd byte crosses it) is decoded per byte.
- Checksum adds each byte whose rom_we is nonzero, registered in the same cycle as the write.
- ioctl_wr while in LO/HI sets overrun and the strobe is discarded.
- ioctl_download falling:
  - In IDLE: go to TAIL.
  - In LO/HI: finish the pending word first, then go to TAIL.
- TAIL:
  - Counter decrements each cycle.
  - At 0: cpu_hold=0, dl_done=1 for one cycle, back to IDLE.
  - A new ioctl_download rise in TAIL aborts back to IDLE with cpu_hold held high and no dl_done.
- When not downloading and not in LO/HI: rom_addr = cpu_ab, rom_we=0.
- Synchronous reset mid-write aborts the write immediately (rom_we=0 the next cycle). No partial-word recovery.
- All outputs are registered; rom_addr/rom_din/rom_we change only on clk_sys.

Decomposition:
- Shared package rom_dl_pkg: state enum (IDLE/LO/HI/TAIL) and region-decode function (byte addr → 4-bit one-hot plus base offset).
- No sub-module needed. Optional tiny hold_timer (down-counter with load/zero flag) is acceptable.

Test Plan:
- Reset then idle, cpu_ab=16'h1234 → rom_addr=16'h1234, rom_we=0, cpu_hold=1 until first download completes; checksum=0.
- Download, one write addr=0, dout=16'hA55A → cycle+1: addr 0, din 5A, we=0001; cycle+2: addr 1, din A5, we=0001; checksum=0x00FF; ioctl_wait high for exactly 2 cycles.
- Write addr=27'h04002 dout=16'h0102 → rom_we=0010, rom_addr=2 then 3; write at 27'h10000 → rom_we stays 0, checksum unchanged.
- ioctl_wr pulsed on the cycle after an accepted write → overrun=1, no third byte written; overrun cleared at the next download rise.
- Drop ioctl_download in LO → HI byte still written, then exactly HOLD_CYC cycles later cpu_hold=0 with a single dl_done pulse.
- Assert reset during HI → next cycle rom_we=0, cpu_hold=1, ioctl_wait=0, checksum=0.
